// File: rtl/ttt_move_ctrl.sv
// ttt_move_ctrl: upstream move controller for ttt_main.
// Turns a single raw confirm button plus a 4-bit cell selector into turn-ordered, validated
// move commands. Illegal confirms (occupied cell, index > 8, game decided) raise a one-cycle
// move_error pulse instead of a command.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_ni              asynchronous active-low reset
//   btn_confirm_i       raw confirm button, asynchronous, active-high
//   sel_position_i      selected cell 0..8, sampled on the confirm pulse only
//   board_i             cell k = board_i[2k+1:2k]; 00 empty, 01 P1, 10 P2
//   who_i               ttt_main result: 00 playing, 01 P1 win, 10 P2 win, 11 draw
//   player1_enable_o    P1 move command, high ENABLE_CYCLES cycles per accepted move
//   player2_enable_o    P2 move command, high ENABLE_CYCLES cycles per accepted move
//   player1_position_o  last accepted P1 cell
//   player2_position_o  last accepted P2 cell
//   turn_o              0 = P1 to move, 1 = P2 to move
//   move_count_o        accepted moves since reset, saturates at 9
//   move_error_o        one-cycle pulse on a rejected confirm
//   game_over_o         high once the game is decided or the board is full
module ttt_move_ctrl #(
    parameter int unsigned ENABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        btn_confirm_i,
    input  logic [3:0]  sel_position_i,
    input  logic [17:0] board_i,
    input  logic [1:0]  who_i,
    output logic        player1_enable_o,
    output logic        player2_enable_o,
    output logic [3:0]  player1_position_o,
    output logic [3:0]  player2_position_o,
    output logic        turn_o,
    output logic [3:0]  move_count_o,
    output logic        move_error_o,
    output logic        game_over_o
);

    localparam int unsigned HoldW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ENABLE_CYCLES - 1);
    localparam logic [3:0] MaxMoves = 4'd9;

    typedef enum logic [2:0] {
        StP1Wait,
        StP1Issue,
        StP2Wait,
        StP2Issue,
        StOver
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_prev_q;
    logic                   confirm_q;
    logic [HoldW-1:0]       hold_q;
    logic                   p1_en_q, p2_en_q;
    logic [3:0]             p1_pos_q, p2_pos_q;
    logic                   turn_q;
    logic [3:0]             count_q;
    logic                   error_q;
    logic                   over_q;

    // Button synchronizer and registered rising-edge detect; the extra register makes the
    // raw-edge-to-pulse latency SYNC_STAGES+1 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            btn_prev_q <= 1'b0;
            confirm_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_confirm_i};
            btn_prev_q <= sync_q[SYNC_STAGES-1];
            confirm_q  <= sync_q[SYNC_STAGES-1] & ~btn_prev_q;
        end
    end

    // Occupancy of the selected cell; out-of-range selections read as occupied-free here and
    // are rejected by the range check instead.
    logic [1:0] sel_cell;
    always_comb begin
        sel_cell = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (sel_position_i == 4'(k)) begin
                sel_cell = board_i[2*k +: 2];
            end
        end
    end

    logic legal;
    assign legal = (sel_position_i <= 4'd8) && (sel_cell == 2'b00) && (who_i == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StP1Wait;
            hold_q   <= '0;
            p1_en_q  <= 1'b0;
            p2_en_q  <= 1'b0;
            p1_pos_q <= 4'd0;
            p2_pos_q <= 4'd0;
            turn_q   <= 1'b0;
            count_q  <= 4'd0;
            error_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                StP1Wait, StP2Wait: begin
                    if (who_i != 2'b00) begin
                        // A decided game ends play even without a confirm.
                        state_q <= StOver;
                        over_q  <= 1'b1;
                        error_q <= confirm_q;
                    end else if (confirm_q) begin
                        if (legal) begin
                            hold_q <= '0;
                            if (count_q != MaxMoves) begin
                                count_q <= count_q + 4'd1;
                            end
                            if (state_q == StP1Wait) begin
                                p1_pos_q <= sel_position_i;
                                p1_en_q  <= 1'b1;
                                state_q  <= StP1Issue;
                            end else begin
                                p2_pos_q <= sel_position_i;
                                p2_en_q  <= 1'b1;
                                state_q  <= StP2Issue;
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StP1Issue, StP2Issue: begin
                    // Confirms are dropped here; who_i is not consulted until the next WAIT.
                    if (hold_q == HoldLast) begin
                        hold_q  <= '0;
                        p1_en_q <= 1'b0;
                        p2_en_q <= 1'b0;
                        if (count_q == MaxMoves) begin
                            state_q <= StOver;
                            over_q  <= 1'b1;
                        end else begin
                            state_q <= (state_q == StP1Issue) ? StP2Wait : StP1Wait;
                            turn_q  <= ~turn_q;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StOver: begin
                    error_q <= confirm_q;
                end
                default: begin
                    state_q <= StP1Wait;
                end
            endcase
        end
    end

    assign player1_enable_o   = p1_en_q;
    assign player2_enable_o   = p2_en_q;
    assign player1_position_o = p1_pos_q;
    assign player2_position_o = p2_pos_q;
    assign turn_o             = turn_q;
    assign move_count_o       = count_q;
    assign move_error_o       = error_q;
    assign game_over_o        = over_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Scoreboard bench for ttt_move_ctrl: each press pushes the expected outcome (accepted
// command or rejection), a negedge monitor pops and checks it when the DUT responds.
module tb_ttt_move_ctrl;

    localparam int unsigned EnCyc = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [17:0] board = '0;
    logic [1:0]  who = 2'b00;
    logic        en1, en2, turn, merr, gover;
    logic [3:0]  pos1, pos2, mcnt;

    typedef struct packed {
        logic       is_err;
        logic       player;
        logic [3:0] pos;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_turn = 1'b0;
    logic [3:0] exp_cnt = 4'd0;

    ttt_move_ctrl #(
        .ENABLE_CYCLES(EnCyc),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .btn_confirm_i     (btn),
        .sel_position_i    (sel),
        .board_i           (board),
        .who_i             (who),
        .player1_enable_o  (en1),
        .player2_enable_o  (en2),
        .player1_position_o(pos1),
        .player2_position_o(pos2),
        .turn_o            (turn),
        .move_count_o      (mcnt),
        .move_error_o      (merr),
        .game_over_o       (gover)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on each enable rise / error pulse.
    logic prev_en = 1'b0, prev_err = 1'b0;
    int   en_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0; prev_err = 1'b0; en_len = 0;
        end else begin
            n_tests++;
            if (en1 && en2) begin
                n_fail++; $display("FAIL both_enables: en1=%0b en2=%0b required not both", en1, en2);
            end
            if ((en1 || en2) && !prev_en) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_enable: en1=%0b en2=%0b required none", en1, en2);
                end else begin
                    exp_t e;
                    logic [3:0] p;
                    e = sb.pop_front();
                    p = en2 ? pos2 : pos1;
                    if ({1'b0, en2, p, mcnt} !== {e.is_err, e.player, e.pos, e.cnt}) begin
                        n_fail++;
                        $display("FAIL accept: err=0 player=%0d pos=%0d cnt=%0d required err=%0b player=%0d pos=%0d cnt=%0d",
                                 en2 + 1, p, mcnt, e.is_err, e.player + 1, e.pos, e.cnt);
                    end
                end
            end
            if (en1 || en2) en_len++;
            else if (en_len != 0) begin
                n_tests++;
                if (en_len != EnCyc) begin
                    n_fail++; $display("FAIL enable_len: got %0d cycles required %0d", en_len, EnCyc);
                end
                en_len = 0;
            end
            if (merr && !prev_err) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_error: move_error=1 required 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_err !== 1'b1) begin
                        n_fail++; $display("FAIL error_vs_accept: got move_error required accept of cell %0d", e.pos);
                    end
                end
            end
            if (merr && prev_err) begin
                n_fail++; $display("FAIL error_width: move_error high 2+ cycles required 1");
            end
            prev_en  = en1 || en2;
            prev_err = merr;
        end
    end

    task automatic press(input logic [3:0] s, input bit ok);
        exp_t e;
        e.is_err = !ok;
        e.player = exp_turn;
        e.pos    = s;
        e.cnt    = exp_cnt + 4'd1;
        sb.push_back(e);
        sel = s;
        btn = 1'b1;
        repeat (EnCyc + 10) @(posedge clk);
        btn = 1'b0;
        repeat (4) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL press_timeout: %0d outcomes pending required 0", sb.size());
            sb.delete();
        end
        if (ok) begin
            board[2*s +: 2] = exp_turn ? 2'b10 : 2'b01;
            exp_cnt  = exp_cnt + 4'd1;
            exp_turn = ~exp_turn;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        btn = 1'b0; board = '0; who = 2'b00;
        exp_turn = 1'b0; exp_cnt = 4'd0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if ({en1, en2, pos1, pos2, turn, mcnt, merr, gover} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required all 0", {en1, en2, pos1, pos2, turn, mcnt, merr, gover});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({en1, en2, turn, mcnt, merr, gover} !== '0) begin
            n_fail++; $display("FAIL after_reset: got %b required all 0", {en1, en2, turn, mcnt, merr, gover});
        end
    endtask

    task automatic test_first_move();
        press(4'd4, 1'b1);
        n_tests++;
        if ({pos1, mcnt, turn} !== {4'd4, 4'd1, 1'b1}) begin
            n_fail++; $display("FAIL first_move: pos1=%0d cnt=%0d turn=%0b required 4 1 1", pos1, mcnt, turn);
        end
    endtask

    task automatic test_occupied();
        press(4'd4, 1'b0);
        n_tests++;
        if ({turn, mcnt} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL occupied_state: turn=%0b cnt=%0d required 1 1", turn, mcnt);
        end
        press(4'd1, 1'b1);
        n_tests++;
        if ({pos2, turn, mcnt, pos1} !== {4'd1, 1'b0, 4'd2, 4'd4}) begin
            n_fail++; $display("FAIL p2_move: pos2=%0d turn=%0b cnt=%0d pos1=%0d required 1 0 2 4", pos2, turn, mcnt, pos1);
        end
    endtask

    task automatic test_bad_index();
        press(4'd9, 1'b0);
        press(4'd15, 1'b0);
        n_tests++;
        if ({mcnt, turn, pos1} !== {4'd2, 1'b0, 4'd4}) begin
            n_fail++; $display("FAIL bad_index: cnt=%0d turn=%0b pos1=%0d required 2 0 4", mcnt, turn, pos1);
        end
    endtask

    task automatic test_win();
        press(4'd8, 1'b1);
        press(4'd2, 1'b1);
        press(4'd0, 1'b1);
        n_tests++;
        if (gover !== 1'b0) begin
            n_fail++; $display("FAIL early_over: game_over=%0b required 0", gover);
        end
        who = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({gover, mcnt, pos1} !== {1'b1, 4'd5, 4'd0}) begin
            n_fail++; $display("FAIL win_over: game_over=%0b cnt=%0d pos1=%0d required 1 5 0", gover, mcnt, pos1);
        end
        press(4'd3, 1'b0);
        n_tests++;
        if ({gover, mcnt} !== {1'b1, 4'd5}) begin
            n_fail++; $display("FAIL over_press: game_over=%0b cnt=%0d required 1 5", gover, mcnt);
        end
    endtask

    task automatic test_full_board();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            press(4'(i), 1'b1);
            n_tests++;
            if (gover !== (i == 8)) begin
                n_fail++; $display("FAIL full_over_%0d: game_over=%0b required %0b", i, gover, i == 8);
            end
        end
        n_tests++;
        if (mcnt !== 4'd9) begin
            n_fail++; $display("FAIL full_count: cnt=%0d required 9", mcnt);
        end
        exp_cnt = 4'd9;
        press(4'd4, 1'b0);
        n_tests++;
        if (mcnt !== 4'd9) begin
            n_fail++; $display("FAIL count_sat: cnt=%0d required 9", mcnt);
        end
    endtask

    // Second raw edge lands its pulse mid-ISSUE; only one command may result.
    task automatic test_confirm_in_issue();
        exp_t e;
        do_reset();
        e = '{is_err: 1'b0, player: 1'b0, pos: 4'd6, cnt: 4'd1};
        sb.push_back(e);
        sel = 4'd6;
        @(posedge clk) #1 btn = 1'b1;
        @(posedge clk) #1 btn = 1'b0;
        @(posedge clk) #1 btn = 1'b1;
        repeat (EnCyc + 10) @(posedge clk);
        btn = 1'b0;
        repeat (4) @(posedge clk);
        n_tests++;
        if (sb.size() != 0 || {mcnt, turn, merr} !== {4'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL issue_confirm: pending=%0d cnt=%0d turn=%0b required 0 1 1", sb.size(), mcnt, turn);
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_issue();
        bit seen;
        exp_t e;
        do_reset();
        e = '{is_err: 1'b0, player: 1'b0, pos: 4'd4, cnt: 4'd1};
        sb.push_back(e);
        sel = 4'd4;
        btn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk) #1;
            seen = en1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL mid_issue_timeout: en1=0 required 1 within 20 cycles");
            sb.delete();
        end
        @(posedge clk) #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({en1, en2, mcnt, turn} !== '0) begin
            n_fail++; $display("FAIL async_reset: en1=%0b cnt=%0d turn=%0b required 0 0 0", en1, mcnt, turn);
        end
        btn = 1'b0; board = '0; exp_turn = 1'b0; exp_cnt = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        press(4'd4, 1'b1);
        n_tests++;
        if ({mcnt, pos1, turn} !== {4'd1, 4'd4, 1'b1}) begin
            n_fail++; $display("FAIL post_reset_move: cnt=%0d pos1=%0d turn=%0b required 1 4 1", mcnt, pos1, turn);
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_occupied();
        test_bad_index();
        test_win();
        test_full_board();
        test_confirm_in_issue();
        test_reset_mid_issue();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
